// File: rtl/serial_job_sequencer.sv
// Byte-serial job sequencer: loads words into the processor shell, starts it,
// waits for completion, then streams the result words back out as bytes.
module serial_job_sequencer #(
    parameter int N_IN_WORDS  = 8,
    parameter int START_INDEX = 8,
    parameter int OUT_BASE    = 8,
    parameter int N_OUT_WORDS = 4,
    parameter int PARK_INDEX  = 15,
    parameter int READ_LAT    = 2,
    parameter int START_TO    = 64,
    parameter int RUN_TO      = 65535
) (
    input  logic        i_Clk,
    input  logic        i_Rstn,
    input  logic        i_rx_valid,
    input  logic [7:0]  i_rx_byte,
    output logic        o_tx_valid,
    output logic [7:0]  o_tx_byte,
    input  logic        i_tx_ready,
    output logic [31:0] o_mem_input,
    output logic [3:0]  o_mem_index,
    input  logic [31:0] i_mem_output,
    input  logic        i_proc_busy,
    output logic        o_done,
    output logic        o_error,
    output logic [2:0]  o_state
);
    // Handshake: a tx byte moves on any cycle with o_tx_valid & i_tx_ready;
    // o_tx_valid/o_tx_byte are held unchanged until that cycle.
    typedef enum logic [2:0] {
        LOAD      = 3'd0,
        START     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        READ      = 3'd4,
        TX        = 3'd5,
        RELEASE   = 3'd6
    } state_t;

    localparam logic [3:0]  PARK_IDX  = 4'(PARK_INDEX);
    localparam logic [3:0]  START_IDX = 4'(START_INDEX);
    localparam logic [3:0]  BASE_IDX  = 4'(OUT_BASE);
    localparam logic [3:0]  LAST_IN   = 4'(N_IN_WORDS - 1);
    localparam logic [3:0]  LAST_OUT  = 4'(N_OUT_WORDS - 1);
    localparam logic [3:0]  LAT       = 4'(READ_LAT);
    localparam logic [15:0] START_LIM = 16'(START_TO - 1);
    localparam logic [15:0] RUN_LIM   = 16'(RUN_TO - 1);

    state_t      state, state_d;
    logic [1:0]  byte_cnt;
    logic [3:0]  word_cnt;
    logic [23:0] shreg;
    logic [15:0] timer, timer_inc;
    logic [3:0]  k;
    logic [3:0]  lat;
    logic [23:0] tx_word;
    logic [1:0]  tx_b;
    logic [3:0]  index_d;
    logic [31:0] input_d;
    logic        done_d, error_d;

    logic rx_take, word_full, last_in, busy_to, run_to, read_cap, tx_fire, tx_last, more;

    assign rx_take   = (state == LOAD) && i_rx_valid;
    assign word_full = rx_take && (byte_cnt == 2'd3);
    assign last_in   = word_full && (word_cnt == LAST_IN);
    assign busy_to   = (state == WAIT_BUSY) && !i_proc_busy && (timer == START_LIM);
    assign run_to    = (state == WAIT_DONE) && i_proc_busy && (timer == RUN_LIM);
    assign read_cap  = (state == READ) && (lat == LAT);
    assign tx_fire   = (state == TX) && o_tx_valid && i_tx_ready;
    assign tx_last   = tx_fire && (tx_b == 2'd3);
    assign more      = (k < LAST_OUT);
    assign timer_inc = (timer == 16'hFFFF) ? timer : timer + 16'd1;
    assign o_state   = state;

    // State register plus the registered shell-port and status outputs.
    always_ff @(posedge i_Clk or negedge i_Rstn) begin
        if (!i_Rstn) begin
            state       <= LOAD;
            o_mem_index <= PARK_IDX;
            o_mem_input <= '0;
            o_done      <= 1'b0;
            o_error     <= 1'b0;
        end else begin
            state       <= state_d;
            o_mem_index <= index_d;
            o_mem_input <= input_d;
            o_done      <= done_d;
            o_error     <= error_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            LOAD:      if (last_in) state_d = START;
            START:     state_d = WAIT_BUSY;
            WAIT_BUSY: begin
                if (i_proc_busy)  state_d = WAIT_DONE;
                else if (busy_to) state_d = RELEASE;
            end
            WAIT_DONE: begin
                if (!i_proc_busy) state_d = READ;
                else if (run_to)  state_d = RELEASE;
            end
            READ:      if (read_cap) state_d = TX;
            TX:        if (tx_last) state_d = more ? READ : RELEASE;
            RELEASE:   state_d = LOAD;
            default:   state_d = LOAD;
        endcase
    end

    // Next values of the shell port: any cycle without a real access parks the index.
    always_comb begin
        index_d = PARK_IDX;
        input_d = o_mem_input;
        done_d  = 1'b0;
        error_d = o_error;
        case (state)
            LOAD: begin
                if (rx_take) error_d = 1'b0;
                if (word_full) begin
                    index_d = word_cnt;
                    input_d = {i_rx_byte, shreg};
                end
            end
            START: begin
                index_d = START_IDX;
                input_d = '0;
            end
            WAIT_BUSY: begin
                if (busy_to) begin
                    error_d = 1'b1;
                    index_d = 4'd0;
                    input_d = '0;
                end
            end
            WAIT_DONE: begin
                if (!i_proc_busy) begin
                    index_d = BASE_IDX;
                end else if (run_to) begin
                    error_d = 1'b1;
                    index_d = 4'd0;
                    input_d = '0;
                end
            end
            READ: if (!read_cap) index_d = BASE_IDX + k;
            TX: begin
                if (tx_last) begin
                    if (more) begin
                        index_d = BASE_IDX + k + 4'd1;
                    end else begin
                        index_d = 4'd0;
                        input_d = '0;
                    end
                end
            end
            RELEASE: done_d = !o_error;
            default: ;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rstn) begin
        if (!i_Rstn) begin
            byte_cnt   <= '0;
            word_cnt   <= '0;
            shreg      <= '0;
            timer      <= '0;
            k          <= '0;
            lat        <= '0;
            tx_word    <= '0;
            tx_b       <= '0;
            o_tx_valid <= 1'b0;
            o_tx_byte  <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (rx_take) begin
                        shreg    <= {i_rx_byte, shreg[23:8]};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (word_full) word_cnt <= word_cnt + 4'd1;
                    end
                end
                START:     timer <= '0;
                WAIT_BUSY: timer <= i_proc_busy ? 16'd0 : timer_inc;
                WAIT_DONE: begin
                    timer <= timer_inc;
                    if (!i_proc_busy) begin
                        k   <= '0;
                        lat <= '0;
                    end
                end
                READ: begin
                    lat <= lat + 4'd1;
                    if (read_cap) begin
                        tx_word    <= i_mem_output[31:8];
                        o_tx_byte  <= i_mem_output[7:0];
                        o_tx_valid <= 1'b1;
                        tx_b       <= '0;
                    end
                end
                TX: begin
                    if (tx_fire) begin
                        if (tx_b == 2'd3) begin
                            o_tx_valid <= 1'b0;
                            k          <= k + 4'd1;
                            lat        <= '0;
                        end else begin
                            tx_b      <= tx_b + 2'd1;
                            o_tx_byte <= tx_word[7:0];
                            tx_word   <= {8'h00, tx_word[23:8]};
                        end
                    end
                end
                RELEASE: begin
                    byte_cnt <= '0;
                    word_cnt <= '0;
                    timer    <= '0;
                    k        <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_job_sequencer.sv
// Bench for serial_job_sequencer: shell memory/busy model, scoreboarded
// shell-port accesses, tx bytes and job-end events.
module tb_serial_job_sequencer;
    localparam logic [3:0] PARK = 4'd15;

    logic        i_Clk = 1'b0;
    logic        i_Rstn;
    logic        i_rx_valid;
    logic [7:0]  i_rx_byte;
    logic        o_tx_valid;
    logic [7:0]  o_tx_byte;
    logic        i_tx_ready;
    logic [31:0] o_mem_input;
    logic [3:0]  o_mem_index;
    logic [31:0] i_mem_output = '0;
    logic        i_proc_busy = 1'b0;
    logic        o_done;
    logic        o_error;
    logic [2:0]  o_state;

    always #5 i_Clk = ~i_Clk;

    serial_job_sequencer dut (
        .i_Clk(i_Clk), .i_Rstn(i_Rstn),
        .i_rx_valid(i_rx_valid), .i_rx_byte(i_rx_byte),
        .o_tx_valid(o_tx_valid), .o_tx_byte(o_tx_byte), .i_tx_ready(i_tx_ready),
        .o_mem_input(o_mem_input), .o_mem_index(o_mem_index), .i_mem_output(i_mem_output),
        .i_proc_busy(i_proc_busy), .o_done(o_done), .o_error(o_error), .o_state(o_state)
    );

    int total = 0;
    int bad = 0;

    logic [7:0]  tx_q[$];
    logic [3:0]  wr_idx_q[$];
    logic [31:0] wr_dat_q[$];
    int          wr_len_q[$];
    int          ev_q[$];

    logic [31:0] job_in[8];
    logic [31:0] res[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input logic [31:0] act);
        total++;
        bad++;
        $display("FAIL %s: got %h want nothing", name, act);
    endtask

    // Shell model: result words readable at indices 8..11 with two cycles of latency.
    logic [31:0] rd_pipe = '0;
    always @(posedge i_Clk) begin
        rd_pipe      <= (o_mem_index >= 4'd8 && o_mem_index <= 4'd11) ? res[o_mem_index[1:0]] : 32'h0;
        i_mem_output <= rd_pipe;
    end

    // Busy model: rises 3 cycles after the start index, falls 2000 cycles later.
    logic       busy_mode;
    int         bcnt = 0;
    logic [3:0] bm_prev = PARK;
    always @(posedge i_Clk) begin
        bm_prev <= o_mem_index;
        if (bcnt != 0) bcnt <= (bcnt >= 2003) ? 0 : bcnt + 1;
        else if (busy_mode && o_mem_index == 4'd8 && bm_prev == 4'd7) bcnt <= 1;
        i_proc_busy <= (bcnt >= 3 && bcnt < 2003);
    end

    // Monitor: shell-port access runs, tx transfers and job-end events.
    logic [3:0]  run_idx = PARK;
    logic [31:0] run_dat = '0;
    int          run_len = 0;
    logic [3:0]  prev_idx = PARK;
    logic        prev_v = 0, prev_r = 0, prev_done = 0, prev_err = 0;
    logic [7:0]  prev_b = '0;
    int          wcnt = 0;
    bit          wactive = 0;
    int          tx_total = 0;

    task automatic end_run();
        logic [3:0]  ei;
        logic [31:0] ed;
        int          el;
        if (wr_idx_q.size() == 0) begin
            fail("wr_extra", {run_idx, run_dat[27:0]});
        end else begin
            ei = wr_idx_q.pop_front();
            ed = wr_dat_q.pop_front();
            el = wr_len_q.pop_front();
            check("wr_index", run_idx, ei);
            if (el != 0) begin
                check("wr_data", run_dat, ed);
                check("wr_cycles", run_len, el);
            end
        end
    endtask

    always @(negedge i_Clk) begin
        if (!i_Rstn) begin
            run_idx = PARK; run_len = 0; prev_idx = PARK;
            prev_v = 0; prev_r = 0; prev_done = 0; prev_err = 0; wactive = 0;
        end else begin
            if (run_idx != PARK && o_mem_index == run_idx && o_mem_input == run_dat) begin
                run_len++;
            end else begin
                if (run_idx != PARK) end_run();
                run_idx = o_mem_index;
                run_dat = o_mem_input;
                run_len = 1;
            end
            if (o_mem_index == 4'd8 && prev_idx == 4'd7) begin
                wactive = 1;
                wcnt = 0;
            end else if (wactive) begin
                wcnt++;
            end
            prev_idx = o_mem_index;

            if (prev_v && !prev_r) begin
                check("tx_hold_valid", o_tx_valid, 1);
                check("tx_hold_byte", o_tx_byte, prev_b);
            end
            if (o_tx_valid && i_tx_ready) begin
                tx_total++;
                if (tx_q.size() == 0) fail("tx_extra", o_tx_byte);
                else check("tx_byte", o_tx_byte, tx_q.pop_front());
            end
            prev_v = o_tx_valid; prev_r = i_tx_ready; prev_b = o_tx_byte;

            if (o_done) check("done_width", prev_done, 0);
            if (o_error && !prev_err) begin
                if (wactive) check("timeout_latency", wcnt, 64);
                else fail("timeout_no_start", wcnt);
            end
            if (o_done || (o_error && !prev_err)) begin
                if (ev_q.size() == 0) fail("job_end_extra", {o_done, o_error});
                else check("job_end", {o_done, o_error}, ev_q.pop_front());
                wactive = 0;
            end
            prev_done = o_done; prev_err = o_error;
        end
    end

    // Ready driver: one 10-cycle stall on byte 6 of the second job.
    bit stall_done = 0;
    initial begin
        i_tx_ready = 1'b1;
        forever begin
            @(posedge i_Clk); #1;
            if (!stall_done && o_tx_valid && tx_total == 22) begin
                i_tx_ready = 1'b0;
                repeat (10) @(posedge i_Clk);
                #1;
                i_tx_ready = 1'b1;
                stall_done = 1;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge i_Clk); #1;
        i_rx_valid = 1'b1;
        i_rx_byte  = b;
        @(posedge i_Clk); #1;
        i_rx_valid = 1'b0;
    endtask

    task automatic push_wr(input logic [3:0] idx, input logic [31:0] dat, input int len);
        wr_idx_q.push_back(idx);
        wr_dat_q.push_back(dat);
        wr_len_q.push_back(len);
    endtask

    task automatic run_job(input bit ok, input bit chk_clear);
        for (int i = 0; i < 8; i++) push_wr(4'(i), job_in[i], 1);
        push_wr(4'd8, 32'h0, 1);
        if (ok) begin
            for (int w = 0; w < 4; w++) begin
                push_wr(4'(8 + w), 32'h0, 0);
                for (int b = 0; b < 4; b++) tx_q.push_back(res[w][8*b +: 8]);
            end
        end
        push_wr(4'd0, 32'h0, 1);
        ev_q.push_back(ok ? 2 : 1);
        for (int i = 0; i < 8; i++) begin
            for (int b = 0; b < 4; b++) begin
                send_byte(job_in[i][8*b +: 8]);
                if (chk_clear && i == 0 && b == 0) begin
                    @(negedge i_Clk);
                    check("error_clear", o_error, 0);
                end
            end
        end
    endtask

    task automatic wait_end(input string name);
        int n = 0;
        while (ev_q.size() != 0 && n < 6000) begin
            @(posedge i_Clk);
            n++;
        end
        if (ev_q.size() != 0) fail(name, ev_q.size());
        repeat (2) @(posedge i_Clk);
    endtask

    task automatic check_reset_values();
        check("rst_index", o_mem_index, PARK);
        check("rst_input", o_mem_input, 0);
        check("rst_tx_valid", o_tx_valid, 0);
        check("rst_tx_byte", o_tx_byte, 0);
        check("rst_done", o_done, 0);
        check("rst_error", o_error, 0);
    endtask

    initial begin
        int tgt;
        int n;
        i_Rstn = 1'b0;
        i_rx_valid = 1'b0;
        i_rx_byte = '0;
        busy_mode = 1'b1;
        res = '{32'h0, 32'h0, 32'h0, 32'h0};
        repeat (3) @(posedge i_Clk);
        @(negedge i_Clk);
        check_reset_values();
        #2 i_Rstn = 1'b1;

        // Job 1: bytes 00..1F
        job_in = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C,
                   32'h13121110, 32'h17161514, 32'h1B1A1918, 32'h1F1E1D1C};
        res = '{32'hDEADBEEF, 32'h11223344, 32'h55667788, 32'h99AABBCC};
        run_job(1, 0);
        wait_end("job1_end_timeout");

        // Job 2: tx stall mid-word
        job_in = '{32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C, 32'h4B5A6978,
                   32'h87969AA5, 32'hB4C3D2E1, 32'hF0E1D2C3, 32'h00000000};
        res = '{32'hCAFEF00D, 32'h01234567, 32'h89ABCDEF, 32'hFFFFFFFF};
        run_job(1, 0);
        wait_end("job2_end_timeout");
        check("stall_seen", stall_done, 1);

        // Job 3: busy never rises
        busy_mode = 1'b0;
        job_in = '{32'hA5A5A5A5, 32'h5A5A5A5A, 32'h00FF00FF, 32'hFF00FF00,
                   32'h80000001, 32'h7FFFFFFE, 32'h13579BDF, 32'h2468ACE0};
        run_job(0, 0);
        wait_end("job3_end_timeout");
        check("error_sticky", o_error, 1);
        repeat (5) @(negedge i_Clk);
        check("error_sticky_idle", o_error, 1);
        busy_mode = 1'b1;

        // Job 4: error cleared by first byte, reset during word 2 transmit
        job_in = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                   32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
        res = '{32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3, 32'hD0D1D2D3};
        tgt = tx_total + 9;
        run_job(1, 1);
        n = 0;
        while (tx_total < tgt && n < 6000) begin
            @(posedge i_Clk); #2;
            n++;
        end
        if (tx_total < tgt) fail("job4_tx_timeout", tx_total);
        i_Rstn = 1'b0;
        #1;
        check_reset_values();
        tx_q.delete();
        wr_idx_q.delete();
        wr_dat_q.delete();
        wr_len_q.delete();
        ev_q.delete();
        repeat (3) @(posedge i_Clk);
        #2 i_Rstn = 1'b1;
        repeat (20) @(posedge i_Clk);

        // Job 5: full job after reset
        job_in = '{32'hFEDCBA98, 32'h76543210, 32'h0BADF00D, 32'hFACEB00C,
                   32'h00000001, 32'h10000000, 32'hC3C3C3C3, 32'h3C3C3C3C};
        res = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10};
        run_job(1, 0);
        wait_end("job5_end_timeout");

        // Job 6: stray bytes while the processor runs
        res = '{32'h600DCAFE, 32'hBAADF00D, 32'h12121212, 32'h34343434};
        run_job(1, 0);
        n = 0;
        while (!i_proc_busy && n < 3000) begin
            @(posedge i_Clk);
            n++;
        end
        if (!i_proc_busy) fail("job6_busy_timeout", n);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        wait_end("job6_end_timeout");

        // Job 7: packing restarts at byte 0
        job_in = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C,
                   32'h13121110, 32'h17161514, 32'h1B1A1918, 32'h1F1E1D1C};
        res = '{32'hDEADBEEF, 32'h00000000, 32'h80808080, 32'h7F7F7F7F};
        run_job(1, 0);
        wait_end("job7_end_timeout");

        check("tx_q_empty", tx_q.size(), 0);
        check("wr_q_empty", wr_idx_q.size(), 0);
        check("ev_q_empty", ev_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
